// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and widths for the SDRAM command queue.
package sdram_pkg;
    localparam int SDRAM_ADDR_WIDTH = 22;
    localparam int SDRAM_DATA_WIDTH = 16;
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } sdram_cmd_t;
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
    typedef struct packed {
        logic                        write;
        logic [SDRAM_ADDR_WIDTH-1:0] address;
        logic [SDRAM_DATA_WIDTH-1:0] data;
    } sdram_req_t;
endpackage

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: synchronous FIFO with registered full/empty flags and a registered head entry.
module sdram_req_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW:0] count, count_n;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rd_next = rd_ptr + AW'(do_pop);
    assign count_n = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
            head <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_next;
            count <= count_n;
            full <= count_n == (AW+1)'(DEPTH);
            empty <= count_n == '0;
            // an entry pushed into a draining FIFO becomes the head straight away
            head <= (do_push && wr_ptr == rd_next) ? din : mem[rd_next];
        end
    end
endmodule

// File: rtl/sdram_cmd_queue.sv
// sdram_cmd_queue: buffers client requests and issues them one at a time to the SDRAM controller.
// Optional watchdog on stalled commands: define SDRAM_CMD_QUEUE_TIMEOUT_EN.
module sdram_cmd_queue
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH     = SDRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = SDRAM_DATA_WIDTH,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  wr_ack,
    output logic                  err,
    output logic [1:0]            command,
    output logic [ADDR_WIDTH-1:0] data_address,
    output logic [DATA_WIDTH-1:0] data_write,
    input  logic [DATA_WIDTH-1:0] data_read,
    input  logic                  data_read_valid,
    input  logic                  data_write_done
);
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
    state_t state, state_n;
    sdram_cmd_t cmd, cmd_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n, rdata_n;
    logic [EW-1:0] head;
    logic rsp_valid_n, wr_ack_n, timeout, pop, full, empty;

    sdram_req_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid),
        .pop   (pop),
        .din   ({req_write, req_address, req_data}),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign req_ready = !full;
    assign command = cmd;

    always_comb begin
        state_n = state;
        cmd_n = cmd;
        addr_n = data_address;
        wdata_n = data_write;
        rdata_n = rsp_data;
        rsp_valid_n = 1'b0;
        wr_ack_n = 1'b0;
        pop = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop = 1'b1;
                cmd_n = head[EW-1] ? CMD_WRITE : CMD_READ;
                addr_n = head[DATA_WIDTH +: ADDR_WIDTH];
                wdata_n = head[DATA_WIDTH-1:0];
                state_n = BUSY;
            end
            // strobes of the wrong kind are ignored; a real completion beats the watchdog
            BUSY: if (cmd == CMD_WRITE && data_write_done) begin
                cmd_n = CMD_IDLE;
                wr_ack_n = 1'b1;
                state_n = GAP;
            end else if (cmd == CMD_READ && data_read_valid) begin
                cmd_n = CMD_IDLE;
                rdata_n = data_read;
                rsp_valid_n = 1'b1;
                state_n = GAP;
            end else if (timeout) begin
                cmd_n = CMD_IDLE;
                state_n = GAP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cmd <= CMD_IDLE;
            data_address <= '0;
            data_write <= '0;
            rsp_data <= '0;
            rsp_valid <= 1'b0;
            wr_ack <= 1'b0;
        end else begin
            state <= state_n;
            cmd <= cmd_n;
            data_address <= addr_n;
            data_write <= wdata_n;
            rsp_data <= rdata_n;
            rsp_valid <= rsp_valid_n;
            wr_ack <= wr_ack_n;
        end
    end

`ifdef SDRAM_CMD_QUEUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] timer;
    assign timeout = timer == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            err <= 1'b0;
        end else begin
            timer <= (state == BUSY) ? timer + 1'b1 : '0;
            err <= state == BUSY && timeout && !rsp_valid_n && !wr_ack_n;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_cmd_queue.sv
// tb_sdram_cmd_queue: randomized bench with a request-level reference model and a latency-driven controller model.
module tb_sdram_cmd_queue;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int TMO = 16;
`ifdef SDRAM_CMD_QUEUE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0, req_ready;
    logic [AW-1:0] req_address = '0, data_address;
    logic [DW-1:0] req_data = '0, rsp_data, data_write, data_read = '0;
    logic rsp_valid, wr_ack, err;
    logic [1:0] command;
    logic data_read_valid = 1'b0, data_write_done = 1'b0;

    always #5 clk = ~clk;

    sdram_cmd_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_data        (req_data),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .wr_ack          (wr_ack),
        .err             (err),
        .command         (command),
        .data_address    (data_address),
        .data_write      (data_write),
        .data_read       (data_read),
        .data_read_valid (data_read_valid),
        .data_write_done (data_write_done)
    );

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_s;

    req_s issue_q[$];
    req_s exp_q[$];
    req_s e;
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ctrl_mem [int];
    int n_checks = 0, n_fail = 0, n_rsp = 0, n_wack = 0;
    bit stall = 0, noise = 0, in_reset = 1;
    int lat_w = 5, lat_r = 7, ccnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Accepted requests go out in order; a read returns whatever the latest earlier write left there.
    function automatic void model_accept(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_s r;
        r.w = w;
        r.a = a;
        r.d = d;
        issue_q.push_back(r);
        if (w) ref_mem[int'(a)] = d;
        else r.d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
        exp_q.push_back(r);
    endfunction

    // Controller model: completes after a latency, optionally sprinkles strobes that must be ignored.
    always @(negedge clk) begin
        data_write_done = 1'b0;
        data_read_valid = 1'b0;
        if (noise && $urandom_range(3) == 0) begin
            data_read = DW'($urandom);
            if (command != 2'd2) data_read_valid = 1'b1;
            if (command != 2'd1) data_write_done = 1'b1;
        end
        if (command == 2'd0 || reset) ccnt = 0;
        else if (!stall) begin
            ccnt++;
            if (command == 2'd1 && ccnt >= lat_w) begin
                ctrl_mem[int'(data_address)] = data_write;
                data_write_done = 1'b1;
            end
            if (command == 2'd2 && ccnt >= lat_r) begin
                data_read = ctrl_mem.exists(int'(data_address)) ? ctrl_mem[int'(data_address)] : '0;
                data_read_valid = 1'b1;
            end
        end
    end

    logic [1:0] prev_cmd = '0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;
    int zero_run = 0, busy_len = 0;
    bit gap_exp = 0;
    logic falling, exp_err;

    always @(negedge clk) begin
        if (in_reset) begin
            prev_cmd = '0;
            zero_run = 0;
            busy_len = 0;
            gap_exp = 0;
        end else begin
            falling = prev_cmd != 2'd0 && command == 2'd0;
            exp_err = TO_EN && falling && busy_len == TMO && !rsp_valid && !wr_ack;
            check("err", err, exp_err);
            check("pulse_off_drop", (rsp_valid || wr_ack || err) && !falling, 0);
            if (rsp_valid || wr_ack || err) begin
                n_rsp += int'(rsp_valid);
                n_wack += int'(wr_ack);
                if (exp_q.size() == 0) check("unexpected_rsp", {rsp_valid, wr_ack, err}, 0);
                else begin
                    e = exp_q.pop_front();
                    if (!err) begin
                        check("rsp_kind", {rsp_valid, wr_ack}, e.w ? 2'b01 : 2'b10);
                        if (!e.w) check("rsp_data", rsp_data, e.d);
                    end
                end
            end
            if (prev_cmd == 2'd0 && command != 2'd0) begin
                if (issue_q.size() == 0) check("spurious_cmd", command, 0);
                else begin
                    e = issue_q.pop_front();
                    check("cmd", command, e.w ? 1 : 2);
                    check("cmd_addr", data_address, e.a);
                    if (e.w) check("cmd_wdata", data_write, e.d);
                    if (gap_exp) check("idle_gap", zero_run, 2);
                end
                busy_len = 1;
            end else if (command != 2'd0) begin
                check("hold_cmd", command, prev_cmd);
                check("hold_addr", data_address, prev_addr);
                check("hold_wdata", data_write, prev_wdata);
                busy_len++;
            end else if (falling) begin
                zero_run = 1;
                gap_exp = issue_q.size() > 0;
            end else zero_run++;
            check("req_ready", req_ready, issue_q.size() < DEPTH);
            prev_cmd = command;
            prev_addr = data_address;
            prev_wdata = data_write;
        end
    end

    // Called at a negedge; returns at the negedge after the request was accepted.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bit acc = 0;
        req_valid = 1'b1;
        req_write = w;
        req_address = a;
        req_data = d;
        while (!acc && n < 500) begin
            acc = req_ready;
            @(posedge clk);
            n++;
            if (!acc) @(negedge clk);
        end
        if (!acc) check("accept_timeout", req_ready, 1);
        else model_accept(w, a, d);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || issue_q.size() != 0 || command != 2'd0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size() + issue_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        in_reset = 1;
        reset = 1'b1;
        issue_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("rst_command", command, 0);
        check("rst_ready", req_ready, 1);
        check("rst_addr", data_address, 0);
        check("rst_wdata", data_write, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        ref_mem = ctrl_mem;
        in_reset = 0;
    endtask

    initial begin
        int saved;
        logic [AW-1:0] a;
        repeat (3) @(negedge clk);
        do_reset();
        // single write then read back
        send(1'b1, 22'h00123, 16'hBEEF);
        send(1'b0, 22'h00123, 16'h0000);
        drain();
        check("t1_wr_acks", n_wack, 1);
        check("t1_rsps", n_rsp, 1);
        // fill with the controller stalled: one in flight plus DEPTH queued
        stall = 1;
        for (int i = 0; i < DEPTH + 1; i++) send(1'b0, AW'(i), 16'h0);
        check("full_ready", req_ready, 0);
        req_valid = 1'b1;
        req_address = 22'h5;
        repeat (4) @(negedge clk);
        check("still_full", req_ready, 0);
        req_valid = 1'b0;
        stall = 0;
        drain();
        // reset while a read is stalled with three more queued
        stall = 1;
        for (int i = 0; i < 4; i++) send(1'b0, AW'(22'h100 + i), 16'h0);
        repeat (2) @(negedge clk);
        saved = n_rsp;
        do_reset();
        stall = 0;
        repeat (40) @(negedge clk);
        check("flush_no_rsp", n_rsp, saved);
        // address/data sweep
        lat_w = 1;
        lat_r = 2;
        for (int i = 0; i <= 16'hFFFE; i += 16'h3F) send(1'b1, AW'(i), 16'(i));
        for (int i = 0; i <= 16'hFFFE; i += 16'h3F) send(1'b0, AW'(i), 16'h0);
        drain();
        // random traffic with ignored strobes
        noise = 1;
        for (int i = 0; i < 400; i++) begin
            lat_w = $urandom_range(1, 8);
            lat_r = $urandom_range(1, 8);
            a = AW'(($urandom_range(0, 3) << 20) | $urandom_range(0, 15));
            send(1'($urandom_range(1)), a, DW'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        noise = 0;
`ifdef SDRAM_CMD_QUEUE_TIMEOUT_EN
        stall = 1;
        send(1'b0, 22'h77, 16'h0);
        send(1'b0, 22'h78, 16'h0);
        for (int n = 0; n < 100 && !err; n++) @(negedge clk);
        check("wd_err_seen", err, 1);
        stall = 0;
        drain();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "global timeout");
    end
endmodule
